// File: rtl/fpu_issue_arbiter.sv
// Round-robin two-requester issue sequencer for the shared multi-cycle FPU.
// Optional WAIT timeout: define FPU_ISSUE_ARBITER_TIMEOUT_EN.
module fpu_issue_arbiter #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        r0_valid,
    input  logic [4:0]  r0_op,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    output logic        r0_ready,
    output logic        r0_rvalid,
    output logic [31:0] r0_result,
    output logic [2:0]  r0_status,
    input  logic        r0_rready,

    input  logic        r1_valid,
    input  logic [4:0]  r1_op,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    output logic        r1_ready,
    output logic        r1_rvalid,
    output logic [31:0] r1_result,
    output logic [2:0]  r1_status,
    input  logic        r1_rready,

    output logic [9:0]  fpu_opcode,
    output logic [31:0] fpu_x1,
    output logic [31:0] fpu_x2,
    input  logic [31:0] fpu_y,
    input  logic        fpu_ovf,
    input  logic        fpu_unf,
    input  logic        fpu_out_valid,

    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("fpu_issue_arbiter: TIMEOUT_CYC must be >= 2");
    end

    state_t      state;
    logic        ptr;
    logic        gid;
    logic [31:0] result_q;
    logic [2:0]  status_q;

    logic        any_req;
    logic        sel_id;
    logic [9:0]  sel_onehot;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        resp_taken;

`ifdef FPU_ISSUE_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] wait_cnt;
`endif

    function automatic logic [9:0] decode_op(input logic [4:0] op);
        logic [9:0] oh;
        // NOTE: default before the case keeps illegal ops at zero and never infers a latch.
        oh = '0;
        case (op)
            5'b10000: oh[0] = 1'b1;
            5'b10001: oh[1] = 1'b1;
            5'b10010: oh[2] = 1'b1;
            5'b10011: oh[3] = 1'b1;
            5'b11011: oh[4] = 1'b1;
            5'b10110: oh[5] = 1'b1;
            5'b10111: oh[6] = 1'b1;
            5'b10101: oh[7] = 1'b1;
            5'b11001: oh[8] = 1'b1;
            5'b11000: oh[9] = 1'b1;
            default:  ;
        endcase
        return oh;
    endfunction

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        any_req    = r0_valid | r1_valid;
        sel_id     = (r0_valid & r1_valid) ? ptr : r1_valid;
        sel_a      = sel_id ? r1_a : r0_a;
        sel_b      = sel_id ? r1_b : r0_b;
        sel_onehot = decode_op(sel_id ? r1_op : r0_op);
        resp_taken = gid ? r1_rready : r0_rready;
    end

    assign r0_ready  = (state == S_IDLE) & any_req & ~sel_id;
    assign r1_ready  = (state == S_IDLE) & any_req & sel_id;
    assign busy      = (state != S_IDLE);
    assign r0_result = result_q;
    assign r1_result = result_q;
    assign r0_status = status_q;
    assign r1_status = status_q;

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= 1'b0;
            gid        <= 1'b0;
            fpu_opcode <= '0;
            fpu_x1     <= '0;
            fpu_x2     <= '0;
            result_q   <= '0;
            status_q   <= '0;
            r0_rvalid  <= 1'b0;
            r1_rvalid  <= 1'b0;
`ifdef FPU_ISSUE_ARBITER_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gid    <= sel_id;
                        ptr    <= ~sel_id;
                        fpu_x1 <= sel_a;
                        fpu_x2 <= sel_b;
                        if (|sel_onehot) begin
                            fpu_opcode <= sel_onehot;
                            state      <= S_ISSUE;
                        end else begin
                            result_q  <= '0;
                            status_q  <= 3'b100;
                            r0_rvalid <= ~sel_id;
                            r1_rvalid <= sel_id;
                            state     <= S_RESP;
                        end
                    end
                end

                S_ISSUE: begin
                    fpu_opcode <= '0;
`ifdef FPU_ISSUE_ARBITER_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                    state      <= S_WAIT;
                end

                S_WAIT: begin
                    if (fpu_out_valid) begin
                        result_q  <= fpu_y;
                        status_q  <= {1'b0, fpu_ovf, fpu_unf};
                        r0_rvalid <= ~gid;
                        r1_rvalid <= gid;
                        state     <= S_RESP;
                    end
`ifdef FPU_ISSUE_ARBITER_TIMEOUT_EN
                    // Count value k means k+1 WAIT cycles elapsed; the counter stops at its limit.
                    else if (wait_cnt >= CNT_W'(TIMEOUT_CYC - 1)) begin
                        result_q  <= '0;
                        status_q  <= 3'b100;
                        r0_rvalid <= ~gid;
                        r1_rvalid <= gid;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                S_RESP: begin
                    if (resp_taken) begin
                        r0_rvalid <= 1'b0;
                        r1_rvalid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Self-checking bench for fpu_issue_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level model of grants, decode and responses.
module tb_fpu_issue_arbiter;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        r0_valid, r1_valid;
    logic [4:0]  r0_op, r1_op;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic        r0_ready, r1_ready;
    logic        r0_rvalid, r1_rvalid;
    logic [31:0] r0_result, r1_result;
    logic [2:0]  r0_status, r1_status;
    logic        r0_rready, r1_rready;
    logic [9:0]  fpu_opcode;
    logic [31:0] fpu_x1, fpu_x2, fpu_y;
    logic        fpu_ovf, fpu_unf, fpu_out_valid;
    logic        busy;

    fpu_issue_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_result(r0_result),
        .r0_status(r0_status), .r0_rready(r0_rready),
        .r1_valid(r1_valid), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_result(r1_result),
        .r1_status(r1_status), .r1_rready(r1_rready),
        .fpu_opcode(fpu_opcode), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2),
        .fpu_y(fpu_y), .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf),
        .fpu_out_valid(fpu_out_valid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transaction-level model state: tie-break pointer and pending requests.
    bit          ptr_m;
    bit          pend_v  [2];
    logic [4:0]  pend_op [2];
    logic [31:0] pend_a  [2];
    logic [31:0] pend_b  [2];

    logic [4:0] legal_ops [10] = '{5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b11011,
                                   5'b10110, 5'b10111, 5'b10101, 5'b11001, 5'b11000};

    function automatic int op_index(input logic [4:0] op);
        for (int i = 0; i < 10; i++)
            if (legal_ops[i] == op) return i;
        return -1;
    endfunction

    function automatic logic [4:0] rand_op();
        if ($urandom_range(0, 4) != 0) return legal_ops[$urandom_range(0, 9)];
        return 5'($urandom);
    endfunction

    function automatic logic rdy(input int n);
        return (n != 0) ? r1_ready : r0_ready;
    endfunction

    function automatic logic rvld(input int n);
        return (n != 0) ? r1_rvalid : r0_rvalid;
    endfunction

    function automatic logic [31:0] res(input int n);
        return (n != 0) ? r1_result : r0_result;
    endfunction

    function automatic logic [2:0] st(input int n);
        return (n != 0) ? r1_status : r0_status;
    endfunction

    task automatic set_rready(input int n, input logic v);
        if (n != 0) r1_rready = v;
        else        r0_rready = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req();
        r0_valid = pend_v[0]; r0_op = pend_op[0]; r0_a = pend_a[0]; r0_b = pend_b[0];
        r1_valid = pend_v[1]; r1_op = pend_op[1]; r1_a = pend_a[1]; r1_b = pend_b[1];
    endtask

    task automatic post(input int n, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        pend_v[n] = 1'b1; pend_op[n] = op; pend_a[n] = a; pend_b[n] = b;
        drive_req();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        ptr_m = 1'b0;
    endtask

    // One full transaction, starting in an IDLE cycle with requests already driven.
    task automatic serve(input int lat, input int bp, input bit use_y, input logic [31:0] y_fix);
        int          g;
        int          idx;
        logic [9:0]  oh;
        logic [31:0] y, exp_res;
        logic [2:0]  exp_st;
        logic        ovf, unf;

        g     = (pend_v[0] && pend_v[1]) ? int'(ptr_m) : (pend_v[1] ? 1 : 0);
        ptr_m = (g == 0);
        idx   = op_index(pend_op[g]);

        #1;
        check("accept_ready", 32'(rdy(g)), 1);
        check("accept_other_ready", 32'(rdy(1 - g)), 0);
        check("accept_busy", 32'(busy), 0);

        step();
        pend_v[g] = 1'b0;
        drive_req();
        #1;
        check("t1_busy", 32'(busy), 1);
        check("t1_other_ready", 32'(rdy(1 - g)), 0);

        if (idx >= 0) begin
            oh = '0;
            oh[idx] = 1'b1;
            check("pulse_opcode", 32'(fpu_opcode), 32'(oh));
            check("pulse_x1", fpu_x1, pend_a[g]);
            check("pulse_x2", fpu_x2, pend_b[g]);
            check("pulse_rvalid", 32'(rvld(g)), 0);
            y   = use_y ? y_fix : $urandom;
            ovf = use_y ? 1'b0 : 1'($urandom_range(0, 1));
            unf = use_y ? 1'b0 : 1'($urandom_range(0, 1));
            for (int i = 1; i <= lat; i++) begin
                step();
                if (i == lat) begin
                    fpu_out_valid = 1'b1; fpu_y = y; fpu_ovf = ovf; fpu_unf = unf;
                end
                #1;
                if (i == 1) begin
                    check("pulse_end_opcode", 32'(fpu_opcode), 0);
                    check("wait_x1_held", fpu_x1, pend_a[g]);
                end
                if (i == lat) check("wait_rvalid", 32'(rvld(g)), 0);
            end
            step();
            fpu_out_valid = 1'b0; fpu_y = $urandom; fpu_ovf = 1'b0; fpu_unf = 1'b0;
            #1;
            exp_res = y;
            exp_st  = {1'b0, ovf, unf};
        end else begin
            check("illegal_no_pulse", 32'(fpu_opcode), 0);
            exp_res = '0;
            exp_st  = 3'b100;
        end

        check("resp_rvalid", 32'(rvld(g)), 1);
        check("resp_other_rvalid", 32'(rvld(1 - g)), 0);
        check("resp_result", res(g), exp_res);
        check("resp_status", 32'(st(g)), 32'(exp_st));

        for (int j = 0; j < bp; j++) begin
            step();
            #1;
            check("bp_rvalid", 32'(rvld(g)), 1);
            check("bp_result", res(g), exp_res);
            check("bp_status", 32'(st(g)), 32'(exp_st));
            check("bp_other_ready", 32'(rdy(1 - g)), 0);
        end

        set_rready(g, 1'b1);
        step();
        set_rready(g, 1'b0);
        #1;
        check("done_rvalid", 32'(rvld(g)), 0);
        check("done_busy", 32'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pend_v = '{1'b0, 1'b0};
        pend_op = '{5'd0, 5'd0};
        pend_a = '{32'd0, 32'd0};
        pend_b = '{32'd0, 32'd0};
        drive_req();
        r0_rready = 1'b0; r1_rready = 1'b0;
        fpu_y = '0; fpu_ovf = 1'b0; fpu_unf = 1'b0; fpu_out_valid = 1'b0;
        ptr_m = 1'b0;
        step();
        step();
        check("rst_opcode", 32'(fpu_opcode), 0);
        check("rst_x1", fpu_x1, 0);
        check("rst_rvalid0", 32'(r0_rvalid), 0);
        check("rst_rvalid1", 32'(r1_rvalid), 0);
        check("rst_result", r0_result, 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        step();

        // Both valid right after reset: r0 first, with the fadd directed case.
        post(0, 5'b10000, 32'h3F80_0000, 32'h4000_0000);
        post(1, 5'b10011, $urandom, $urandom);
        serve(3, 0, 1'b1, 32'h4040_0000);
        serve(2, 0, 1'b0, 32'h0);

        // r1 alone, then both: expected order r1, r0, r1.
        post(1, 5'b10110, $urandom, $urandom);
        serve(1, 0, 1'b0, 32'h0);
        post(0, 5'b11001, $urandom, $urandom);
        post(1, 5'b11000, $urandom, $urandom);
        serve(2, 1, 1'b0, 32'h0);
        serve(4, 0, 1'b0, 32'h0);

        // Illegal op.
        post(0, 5'b01000, $urandom, $urandom);
        serve(1, 0, 1'b0, 32'h0);

        // Reset during WAIT.
        post(0, 5'b10001, $urandom | 32'h1, $urandom | 32'h1);
        #1;
        check("rw_accept", 32'(r0_ready), 1);
        step();
        pend_v[0] = 1'b0;
        drive_req();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("rw_opcode", 32'(fpu_opcode), 0);
        check("rw_x1", fpu_x1, 0);
        check("rw_x2", fpu_x2, 0);
        check("rw_rvalid", 32'(r0_rvalid), 0);
        check("rw_status", 32'(r0_status), 0);
        check("rw_busy", 32'(busy), 0);
        step();
        rst = 1'b0;
        ptr_m = 1'b0;
        step();
        fpu_out_valid = 1'b1; fpu_y = 32'hDEAD_BEEF;
        step();
        fpu_out_valid = 1'b0;
        #1;
        check("late_done_rvalid0", 32'(r0_rvalid), 0);
        check("late_done_rvalid1", 32'(r1_rvalid), 0);
        check("late_done_busy", 32'(busy), 0);
        step();

        // Backpressure: r0 holds its result for 5 cycles while r1 waits.
        post(0, 5'b10111, $urandom, $urandom);
        post(1, 5'b10101, $urandom, $urandom);
        serve(2, 5, 1'b0, 32'h0);
        serve(1, 0, 1'b0, 32'h0);

        // Missing completion.
        post(0, 5'b10010, $urandom, $urandom);
        ptr_m = 1'b1;
        #1;
        check("to_accept", 32'(r0_ready), 1);
        step();
        pend_v[0] = 1'b0;
        drive_req();
        #1;
        check("to_pulse", 32'(fpu_opcode), 32'h4);
`ifdef FPU_ISSUE_ARBITER_TIMEOUT_EN
        for (int i = 1; i <= TO; i++) begin
            step();
            #1;
            if (i == TO) check("to_wait_rvalid", 32'(r0_rvalid), 0);
        end
        step();
        #1;
        check("to_rvalid", 32'(r0_rvalid), 1);
        check("to_result", r0_result, 0);
        check("to_status", 32'(r0_status), 32'h4);
        r0_rready = 1'b1;
        step();
        r0_rready = 1'b0;
        #1;
        check("to_done_busy", 32'(busy), 0);
`else
        repeat (100) step();
        #1;
        check("hang_busy", 32'(busy), 1);
        check("hang_rvalid", 32'(r0_rvalid), 0);
        do_reset();
        #1;
        check("hang_reset_busy", 32'(busy), 0);
        step();
`endif

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            for (int n = 0; n < 2; n++)
                if (!pend_v[n] && ($urandom_range(0, 1) != 0))
                    post(n, rand_op(), $urandom, $urandom);
            if (!pend_v[0] && !pend_v[1])
                post(int'($urandom_range(0, 1)), rand_op(), $urandom, $urandom);
            serve(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), 1'b0, 32'h0);
        end
        while (pend_v[0] || pend_v[1])
            serve(int'($urandom_range(1, 3)), 0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_issue_arbiter.md
# fpu_issue_arbiter

Sequencer and two-way arbiter for the shared multi-cycle floating-point unit (`fpu_top`). It accepts FP operation requests from two requesters, for example the core EX stage and a second issuing agent. It grants one request at a time with round-robin priority, drives the unit's one-hot opcode pulse and operands, waits for completion, and returns the result and flags to the granted requester with a valid/ready handshake.

## Interface
- `TIMEOUT_CYC`, default 64: cycles in WAIT before a missing completion is declared; must be ≥2.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rN_valid` in 1 (N = 0, 1): request valid; must stay asserted with stable payload until `rN_ready`.
- `rN_op` in 5: op code in ALU-control encoding (bit 4 set = FP op).
- `rN_a`, `rN_b` in 32: operands.
- `rN_ready` out 1: request accepted this cycle.
- `rN_rvalid` out 1: result valid.
- `rN_result` out 32: result.
- `rN_status` out 3: {err, ovf, unf}.
- `rN_rready` in 1: requester accepts the result.
- `fpu_opcode` out 10: one-hot op to the FPU.
- `fpu_x1`, `fpu_x2` out 32: operands to the FPU.
- `fpu_y` in 32: FPU result.
- `fpu_ovf`, `fpu_unf` in 1: FPU flags.
- `fpu_out_valid` in 1: FPU completion.
- `busy` out 1: the FSM is not in IDLE.

## Operation
- Op decode to `fpu_opcode` bit:
  - 10000→0, 10001→1, 10010→2, 10011→3, 11011→4
  - 10110→5, 10111→6, 10101→7, 11001→8, 11000→9
- Any other op is illegal.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `rN_valid` is set, grant per the priority pointer. `rN_ready` is combinational and high for exactly that cycle, for the grantee only.
  - Latch op, a, b and grantee id.
  - Legal op → ISSUE. Illegal op → RESP with result 0 and status 100.
- ISSUE:
  - `fpu_opcode` = decoded one-hot for exactly one cycle.
  - `fpu_x1`/`fpu_x2` = latched operands.
  - Clear the wait counter, then go to WAIT.
- WAIT:
  - `fpu_opcode` = 0; operands held.
  - On `fpu_out_valid`: latch `fpu_y`, set status to {0, `fpu_ovf`, `fpu_unf`}, go to RESP.
  - `fpu_out_valid` is ignored in every other state.
- RESP:
  - Grantee's `rN_rvalid` = 1; result and status held stable.
  - On `rN_rready`, go to IDLE.
  - The other requester's `rvalid` is always 0.
- Priority pointer:
  - Resets to 0.
  - On every grant it moves to the non-granted index.
  - A lone valid requester is always granted.
- No new request is accepted outside IDLE, so there is one bubble cycle between consecutive ops.
- Reset:
  - All outputs are 0; state = IDLE; pointer = 0.
  - Asserting `rst` mid-operation drops the operation. `fpu_opcode` goes to 0 asynchronously.
  - A late `fpu_out_valid` after reset is ignored, because it arrives in IDLE.

## Timing
- Accept at cycle T (IDLE, `rN_ready` = 1).
- Opcode pulse at T+1.
- WAIT from T+2.
- If `fpu_out_valid` is seen at cycle W, `rN_rvalid` rises at W+1.
- Illegal op: `rvalid` at T+1, with no opcode pulse.
- RESP handshake at cycle R → IDLE at R+1; the next accept is possible at R+1.
- All outputs are registered except `rN_ready` and `busy`.

## Configuration
- `FPU_ISSUE_ARBITER_TIMEOUT_EN` defined:
  - WAIT counts cycles.
  - At count `TIMEOUT_CYC` with no completion → RESP with result 0 and status 100.
  - The counter saturates and is cleared in ISSUE.
- Undefined:
  - No counter logic; WAIT persists until `fpu_out_valid`.

## Test plan
- Fadd:
  - Stimulus: r0 op 10000, a=0x3F800000, b=0x40000000; model asserts `fpu_out_valid` 3 cycles after the pulse with y=0x40400000.
  - Required: `fpu_opcode`=0000000001 for exactly one cycle, then `r0_rvalid`=1 with result 0x40400000 and status 000.
- Arbitration:
  - Stimulus: r1 alone, then r0 and r1 both valid.
  - Required: grant order r1, r0, r1, with the bubble cycle between each.
  - Stimulus: both valid right after reset.
  - Required: r0 is granted first.
- Illegal op:
  - Stimulus: r0 op 01000.
  - Required: no opcode pulse; `r0_rvalid` at T+1 with result 0 and status 100.
- Backpressure:
  - Stimulus: `r0_rready` held low for 5 cycles while `r1_valid`=1.
  - Required: result stable; `r1_ready` stays 0; r1 is granted one cycle after the r0 handshake.
- Timeout:
  - Stimulus: macro defined, `TIMEOUT_CYC`=8, model never completes.
  - Required: `rvalid` with result 0 and status 100 after 8 WAIT cycles.
  - Stimulus: macro undefined.
  - Required: `busy` stays 1 indefinitely.
- Reset in WAIT:
  - Stimulus: assert `rst` during WAIT.
  - Required: all outputs 0 asynchronously.
  - Stimulus: a later `fpu_out_valid`.
  - Required: no `rvalid`.
